// File: rtl/fir_decimator.sv
`default_nettype none
// ============================================================================
// fir_decimator: block-average decimator with rounding, saturation, out FIFO
// Revision: 1.0
// ============================================================================
module fir_decimator #(
  parameter int DECIM      = 4,
  parameter int OUT_SHIFT  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic signed [15:0]            din_i,
  input  logic                          din_valid_i,
  input  logic                          out_ready_i,
  output logic signed [7:0]             dout_o,
  output logic                          dout_valid_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = 16 + LOG2D + 1;
  localparam int RND_W = ACC_W + 1;
  localparam int SHIFT = LOG2D + OUT_SHIFT;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [LOG2D-1:0] LAST_CNT = LOG2D'(DECIM - 1);
  localparam logic [LOG2D-1:0] CNT_ONE  = LOG2D'(1);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    OCC_ONE  = CW'(1);
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(127);
  localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-128);

  // Accumulation and dump stage
  logic [LOG2D-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] dump_sum_q, dump_sum_d;
  logic                    dump_valid_q, dump_valid_d;
  logic signed [ACC_W-1:0] din_ext;

  assign din_ext = {{(ACC_W-16){din_i[15]}}, din_i};

  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    dump_sum_d   = dump_sum_q;
    dump_valid_d = 1'b0;
    if (din_valid_i) begin
      if (cnt_q == LAST_CNT) begin
        dump_sum_d   = acc_q + din_ext;
        dump_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = acc_q + din_ext;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      dump_sum_q   <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      dump_sum_q   <= dump_sum_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  // Rounding: one spare bit keeps the half-LSB addition from wrapping
  logic signed [RND_W-1:0] sum_ext;
  logic signed [RND_W-1:0] shifted;
  logic signed [7:0]       sat_res;

  assign sum_ext = {dump_sum_q[ACC_W-1], dump_sum_q};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RND_W-1:0] HALF = {{(RND_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign shifted = (sum_ext + HALF) >>> SHIFT;
    end else begin : g_noround
      assign shifted = sum_ext;
    end
  endgenerate

  always_comb begin
    sat_res = shifted[7:0];
    if (shifted > SAT_MAX) begin
      sat_res = 8'h7F;
    end else if (shifted < SAT_MIN) begin
      sat_res = 8'h80;
    end
  end

  // Output FIFO with a registered head
  logic signed [7:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic signed [7:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, full, push_ok;

  assign push    = dump_valid_q;
  assign pop     = dout_valid_q & out_ready_i;
  assign full    = (count_q == CNT_FULL);
  assign push_ok = push & (~full | pop);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok && !pop) begin
      count_d = count_q + OCC_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - OCC_ONE;
    end
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end

    // New head is the incoming result only when nothing older remains
    if (count_d != '0) begin
      dout_valid_d = 1'b1;
      if (push_ok && (count_q == '0 || (count_q == OCC_ONE && pop))) begin
        dout_d = sat_res;
      end else begin
        dout_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= sat_res;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;

endmodule
`default_nettype wire

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter DECIM, default 4: decimation ratio; SHALL be a power of two, 2..64.
REQ-002 Parameter OUT_SHIFT, default 4: extra right-shift applied after averaging, 0..8.
REQ-003 Parameter FIFO_DEPTH, default 4: output FIFO entries; SHALL be a power of two, 2..16.
REQ-004 Clk  input  1: single clock; all state updates on rising edge.
REQ-005 Rst  input  1: asynchronous, active-high reset.
REQ-006 Din  input  16 signed: filtered sample from the FIR stage (its Yout).
REQ-007 Din_valid  input  1: Din carries a new sample this cycle.
REQ-008 Out_ready  input  1: consumer accepts Dout this cycle.
REQ-009 Dout  output  8 signed: FIFO head sample, registered.
REQ-010 Dout_valid  output  1: FIFO non-empty; Dout is meaningful.
REQ-011 Overflow  output  1: sticky flag; a result was dropped because the FIFO was full.
REQ-012 Fifo_count  output  clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.

Function
REQ-013 Sample counter SHALL advance only on cycles with Din_valid=1 and SHALL hold otherwise.
REQ-014 Accumulator width SHALL be 16+log2(DECIM)+1 bits, signed; no internal wrap is permitted.
REQ-015 On valid samples 1..DECIM-1 of a group: acc <= acc + sign-extended Din.
REQ-016 On the DECIM-th valid sample (dump edge): sum = acc + Din is registered into a dump stage with dump_valid=1; acc <= 0; counter <= 0.
REQ-017 Total shift S = log2(DECIM)+OUT_SHIFT; result = (sum + 2^(S-1)) >>> S (arithmetic, round-half-up); if S=0, no rounding term.
REQ-018 Result SHALL saturate to [-128, +127] before entering the FIFO.
REQ-019 Latency: the saturated result SHALL be written to the FIFO on the edge after the dump edge; Dout_valid SHALL be high in the cycle following that write (at most 2 edges after the dump edge).
REQ-020 Pop occurs when Dout_valid=1 and Out_ready=1; the next entry (if any) appears on Dout the following cycle.
REQ-021 Out_ready while Dout_valid=0 SHALL have no effect.
REQ-022 Push when full and no pop: result SHALL be dropped, FIFO contents unchanged, Overflow set to 1.
REQ-023 Simultaneous push and pop when full: both SHALL succeed, Fifo_count unchanged, Overflow not set.
REQ-024 Simultaneous push and pop when empty is impossible (pop requires valid); push proceeds normally.
REQ-025 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; ordering SHALL be strictly first-in-first-out.
REQ-026 Overflow SHALL remain set until reset.
REQ-027 Dout SHALL hold its value while Dout_valid=1 and Out_ready=0.

Reset
REQ-028 Rst=1 SHALL immediately clear: accumulator, sample counter, dump stage, FIFO pointers, Fifo_count=0, Dout=0, Dout_valid=0, Overflow=0.
REQ-029 Reset mid-group SHALL discard the partial accumulation; the first valid sample after release starts a new group.
REQ-030 A result in the dump stage at reset SHALL be discarded, not written.
REQ-031 Din_valid and Out_ready SHALL be ignored while Rst=1.

Verification (DECIM=4, OUT_SHIFT=4, FIFO_DEPTH=4, S=6)
REQ-032 Four consecutive valid Din=100, Out_ready=1 -> sum 400, Dout=6, Dout_valid high for one cycle, 2 edges after 4th sample.
REQ-033 Four valid Din=16000, then four valid Din=-16000 -> Dout=+127, then Dout=-128 (saturation both directions).
REQ-034 Valid samples 64,x,64,x,64,x,64 with Din_valid low on x cycles -> exactly one output, Dout=4; gaps do not advance counter.
REQ-035 Out_ready=0, 20 valid Din=640 -> five results of 40 produced; Fifo_count reaches 4, fifth dropped, Overflow=1; then Out_ready=1 drains exactly four 40s.
REQ-036 Rst pulsed after 2 of 4 valid samples, then four valid Din=-32 -> single Dout=-2 (rounding of -128), no residue from the pre-reset samples, Overflow=0.
REQ-037 FIFO full with Out_ready=1 on the dump-write edge -> push and pop both occur, Fifo_count stays 4, Overflow stays 0.
